// File: rtl/axil_pkg.sv
// Shared AXI-Lite command-master types: FSM states, response codes, bus widths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axil_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;
    localparam int RESP_W = 2;
    localparam int PROT_W = 3;
    localparam int WAIT_W = 16;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    // Unprivileged, secure, data access for every request.
    localparam logic [PROT_W-1:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DRAIN,
        RSP
    } state_t;

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI-Lite bus bundle (AR/R/AW/W/B channels) between a master and a slave.
// Latency: none, wires only.
// Backpressure: standard per-channel valid/ready.
interface axil_cmd_master_if;

    // Read address channel
    logic                            arvalid;
    logic                            arready;
    logic [axil_pkg::ADDR_W-1:0]     araddr;
    logic [axil_pkg::PROT_W-1:0]     arprot;
    // Read data channel
    logic                            rvalid;
    logic                            rready;
    logic [axil_pkg::DATA_W-1:0]     rdata;
    logic [axil_pkg::RESP_W-1:0]     rresp;
    // Write address channel
    logic                            awvalid;
    logic                            awready;
    logic [axil_pkg::ADDR_W-1:0]     awaddr;
    logic [axil_pkg::PROT_W-1:0]     awprot;
    // Write data channel
    logic                            wvalid;
    logic                            wready;
    logic [axil_pkg::DATA_W-1:0]     wdata;
    logic [axil_pkg::STRB_W-1:0]     wstrb;
    // Write response channel
    logic                            bvalid;
    logic                            bready;
    logic [axil_pkg::RESP_W-1:0]     bresp;

    modport master (
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready,
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready,
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready
    );

endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding command-to-AXI-Lite master with response timeout and late-response drain.
// Latency: AXI valids rise 1 cycle after command accept; response 1 cycle after the R/B handshake.
// Backpressure: cmd_ready only in IDLE; rsp_* held until rsp_ready; address phase waits without timeout.
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic                 m_axi_aclk,
    input  logic                 m_axi_areset,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [DATA_W-1:0]    cmd_wdata,
    input  logic [STRB_W-1:0]    cmd_wstrb,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic [RESP_W-1:0]    rsp_resp,
    output logic                 rsp_timeout,

    axil_cmd_master_if.master    m_axi
);

    // Last wait-counter value before the slave is declared unresponsive.
    localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              state;
    logic                is_wr;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                arvalid_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                rready_q;
    logic                bready_q;

    logic                aw_done;
    logic                w_done;

    // A write channel counts as done once its valid has gone or its handshake is happening now.
    assign aw_done = !awvalid_q || m_axi.awready;
    assign w_done  = !wvalid_q  || m_axi.wready;

    // Captured command drives both address channels; only the selected one is ever valid.
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = PROT_DEFAULT;
    assign m_axi.rready  = rready_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = PROT_DEFAULT;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.bready  = bready_q;

    // Transaction FSM with all handshake and response outputs registered.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            is_wr       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wait_cnt    <= '0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            rready_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_OKAY;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        is_wr     <= cmd_write;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end

                // No timeout here: a valid, once raised, must stay up until accepted.
                RD_ADDR: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= RD_DATA;
                    end
                end

                // A handshake on the final wait cycle takes priority over the timeout.
                RD_DATA: begin
                    if (m_axi.rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_rdata   <= m_axi.rdata;
                        rsp_resp    <= m_axi.rresp;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RSP;
                    end else if (wait_cnt == TMO_LAST) begin
                        rsp_rdata   <= '0;
                        rsp_resp    <= RESP_SLVERR;
                        rsp_timeout <= 1'b1;
                        state       <= DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                // AW and W are independent; each valid drops on its own handshake.
                WR_REQ: begin
                    if (m_axi.awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (m_axi.wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_rdata   <= '0;
                        rsp_resp    <= m_axi.bresp;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= RSP;
                    end else if (wait_cnt == TMO_LAST) begin
                        rsp_rdata   <= '0;
                        rsp_resp    <= RESP_SLVERR;
                        rsp_timeout <= 1'b1;
                        state       <= DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                // Swallow the late response so the slave is free before the next command.
                DRAIN: begin
                    if (is_wr ? m_axi.bvalid : m_axi.rvalid) begin
                        rready_q  <= 1'b0;
                        bready_q  <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end

                // cmd_ready rises only after the response handshake edge.
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master (TIMEOUT=16): read, write, timeout, collision, backpressure, reset.
// Latency: inputs change 1 time unit after each rising edge; outputs sampled at that same point.
// Backpressure: slave and response-side readies are driven directly per scenario.
module tb_axil_cmd_master;
    import axil_pkg::*;

    localparam int TMO = 16;

    logic                m_axi_aclk;
    logic                m_axi_areset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [STRB_W-1:0]   cmd_wstrb;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [RESP_W-1:0]   rsp_resp;
    logic                rsp_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    axil_cmd_master_if m_axi();

    axil_cmd_master #(.TIMEOUT(TMO)) dut (
        .m_axi_aclk   (m_axi_aclk),
        .m_axi_areset (m_axi_areset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .rsp_timeout  (rsp_timeout),
        .m_axi        (m_axi)
    );

    initial m_axi_aclk = 1'b0;
    always #5 m_axi_aclk = ~m_axi_aclk;

    task automatic tick();
        @(posedge m_axi_aclk);
        #1;
    endtask

    task automatic test_reset();
        m_axi_areset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({m_axi.arvalid, m_axi.awvalid, m_axi.wvalid, m_axi.rready, m_axi.bready, rsp_valid, rsp_timeout} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b exp 0000000",
                     {m_axi.arvalid, m_axi.awvalid, m_axi.wvalid, m_axi.rready, m_axi.bready, rsp_valid, rsp_timeout});
        end
        n_checks++;
        if (rsp_rdata !== 64'd0 || rsp_resp !== 2'b00 || dut.wait_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h resp=%b cnt=%0d exp 0/0/0", rsp_rdata, rsp_resp, dut.wait_cnt);
        end
        m_axi_areset = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b1 || dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_release: got cmd_ready=%b state=%0d exp 1/IDLE", cmd_ready, dut.state);
        end
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || m_axi.arprot !== 3'b000 || m_axi.awprot !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_hold: got cmd_ready=%b arprot=%b awprot=%b exp 1/000/000",
                     cmd_ready, m_axi.arprot, m_axi.awprot);
        end
    endtask

    task automatic test_read();
        m_axi.arready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h008;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (m_axi.arvalid !== 1'b1 || m_axi.araddr !== 12'h008 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ar: got arvalid=%b araddr=%h cmd_ready=%b exp 1/008/0",
                     m_axi.arvalid, m_axi.araddr, cmd_ready);
        end
        tick();
        n_checks++;
        if (m_axi.arvalid !== 1'b0 || m_axi.rready !== 1'b1) begin
            n_fail++;
            $display("FAIL read_ar_once: got arvalid=%b rready=%b exp 0/1", m_axi.arvalid, m_axi.rready);
        end
        tick();
        tick();
        m_axi.rvalid = 1'b1; m_axi.rdata = 64'h0000_0001_2345_6789; m_axi.rresp = 2'b00;
        tick();
        m_axi.rvalid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0000_0001_2345_6789 || rsp_resp !== 2'b00
            || rsp_timeout !== 1'b0 || m_axi.rready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rsp: got v=%b rdata=%h resp=%b to=%b rready=%b exp 1/0000000123456789/00/0/0",
                     rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, m_axi.rready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL read_done: got rsp_valid=%b cmd_ready=%b exp 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_write();
        m_axi.awready = 1'b0; m_axi.wready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h010;
        cmd_wdata = 64'hDEAD_BEEF_0000_0001; cmd_wstrb = 8'hFF;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (m_axi.awvalid !== 1'b1 || m_axi.wvalid !== 1'b1 || m_axi.awaddr !== 12'h010
            || m_axi.wdata !== 64'hDEAD_BEEF_0000_0001 || m_axi.wstrb !== 8'hFF || m_axi.arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_req: got awv=%b wv=%b awaddr=%h wdata=%h wstrb=%h arv=%b exp 1/1/010/deadbeef00000001/ff/0",
                     m_axi.awvalid, m_axi.wvalid, m_axi.awaddr, m_axi.wdata, m_axi.wstrb, m_axi.arvalid);
        end
        m_axi.wready = 1'b1;
        tick();
        m_axi.wready = 1'b0;
        n_checks++;
        if (m_axi.wvalid !== 1'b0 || m_axi.awvalid !== 1'b1 || m_axi.bready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_w_first: got wv=%b awv=%b bready=%b exp 0/1/0", m_axi.wvalid, m_axi.awvalid, m_axi.bready);
        end
        tick();
        n_checks++;
        if (m_axi.wvalid !== 1'b0 || m_axi.awvalid !== 1'b1 || m_axi.bready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_aw_wait: got wv=%b awv=%b bready=%b exp 0/1/0", m_axi.wvalid, m_axi.awvalid, m_axi.bready);
        end
        m_axi.awready = 1'b1;
        tick();
        m_axi.awready = 1'b0;
        n_checks++;
        if (m_axi.awvalid !== 1'b0 || m_axi.bready !== 1'b1 || dut.state !== WR_RESP) begin
            n_fail++;
            $display("FAIL write_aw_done: got awv=%b bready=%b state=%0d exp 0/1/WR_RESP",
                     m_axi.awvalid, m_axi.bready, dut.state);
        end
        m_axi.bvalid = 1'b1; m_axi.bresp = 2'b00;
        tick();
        m_axi.bvalid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 64'd0
            || rsp_timeout !== 1'b0 || m_axi.bready !== 1'b0) begin
            n_fail++;
            $display("FAIL write_rsp: got v=%b resp=%b rdata=%h to=%b bready=%b exp 1/00/0/0/0",
                     rsp_valid, rsp_resp, rsp_rdata, rsp_timeout, m_axi.bready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done: got cmd_ready=%b rsp_valid=%b exp 1/0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_timeout();
        m_axi.arready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h020;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < TMO - 1; i++) tick();
        n_checks++;
        if (dut.state !== RD_DATA || rsp_timeout !== 1'b0 || dut.wait_cnt !== 16'(TMO - 1)) begin
            n_fail++;
            $display("FAIL tmo_before: got state=%0d to=%b cnt=%0d exp RD_DATA/0/%0d",
                     dut.state, rsp_timeout, dut.wait_cnt, TMO - 1);
        end
        tick();
        n_checks++;
        if (dut.state !== DRAIN || rsp_timeout !== 1'b1 || rsp_resp !== 2'b10
            || rsp_rdata !== 64'd0 || rsp_valid !== 1'b0 || m_axi.rready !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_fire: got state=%0d to=%b resp=%b rdata=%h v=%b rready=%b exp DRAIN/1/10/0/0/1",
                     dut.state, rsp_timeout, rsp_resp, rsp_rdata, rsp_valid, m_axi.rready);
        end
        tick();
        tick();
        n_checks++;
        if (dut.state !== DRAIN || m_axi.rready !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_drain: got state=%0d rready=%b cmd_ready=%b exp DRAIN/1/0",
                     dut.state, m_axi.rready, cmd_ready);
        end
        m_axi.rvalid = 1'b1; m_axi.rdata = 64'hFFFF_FFFF_FFFF_FFFF; m_axi.rresp = 2'b00;
        tick();
        m_axi.rvalid = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_resp !== 2'b10
            || rsp_rdata !== 64'd0 || m_axi.rready !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_rsp: got v=%b to=%b resp=%b rdata=%h rready=%b exp 1/1/10/0/0",
                     rsp_valid, rsp_timeout, rsp_resp, rsp_rdata, m_axi.rready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b1 || dut.state !== IDLE) begin
            n_fail++;
            $display("FAIL tmo_idle: got cmd_ready=%b state=%0d exp 1/IDLE", cmd_ready, dut.state);
        end
    endtask

    task automatic test_same_cycle();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h030;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < TMO - 1; i++) tick();
        m_axi.rvalid = 1'b1; m_axi.rdata = 64'h1122_3344_5566_7788; m_axi.rresp = 2'b00;
        tick();
        m_axi.rvalid = 1'b0;
        n_checks++;
        if (dut.state !== RSP || rsp_valid !== 1'b1 || rsp_timeout !== 1'b0
            || rsp_resp !== 2'b00 || rsp_rdata !== 64'h1122_3344_5566_7788) begin
            n_fail++;
            $display("FAIL same_cycle: got state=%0d v=%b to=%b resp=%b rdata=%h exp RSP/1/0/00/1122334455667788",
                     dut.state, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h040;
        tick();
        cmd_valid = 1'b0;
        tick();
        m_axi.rvalid = 1'b1; m_axi.rdata = 64'hA5A5_5A5A_0F0F_F0F0; m_axi.rresp = 2'b01;
        tick();
        m_axi.rvalid = 1'b0; m_axi.rdata = 64'd0; m_axi.rresp = 2'b11;
        // A write is offered throughout the stall; it must wait for IDLE.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h050;
        cmd_wdata = 64'h0123_4567_89AB_CDEF; cmd_wstrb = 8'h0F;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hA5A5_5A5A_0F0F_F0F0 || rsp_resp !== 2'b01
                || rsp_timeout !== 1'b0 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b rdata=%h resp=%b to=%b cmd_ready=%b exp 1/a5a55a5a0f0ff0f0/01/0/0",
                         i, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b1 || dut.state !== IDLE || m_axi.awvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got cmd_ready=%b state=%0d awv=%b exp 1/IDLE/0",
                     cmd_ready, dut.state, m_axi.awvalid);
        end
    endtask

    task automatic test_back_to_back();
        m_axi.awready = 1'b1; m_axi.wready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if (m_axi.awvalid !== 1'b1 || m_axi.wvalid !== 1'b1 || m_axi.wstrb !== 8'h0F
            || m_axi.wdata !== 64'h0123_4567_89AB_CDEF || m_axi.awaddr !== 12'h050) begin
            n_fail++;
            $display("FAIL b2b_accept: got awv=%b wv=%b wstrb=%h wdata=%h awaddr=%h exp 1/1/0f/0123456789abcdef/050",
                     m_axi.awvalid, m_axi.wvalid, m_axi.wstrb, m_axi.wdata, m_axi.awaddr);
        end
        tick();
        m_axi.awready = 1'b0; m_axi.wready = 1'b0;
        n_checks++;
        if (m_axi.awvalid !== 1'b0 || m_axi.wvalid !== 1'b0 || m_axi.bready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_both_hs: got awv=%b wv=%b bready=%b exp 0/0/1", m_axi.awvalid, m_axi.wvalid, m_axi.bready);
        end
    endtask

    task automatic test_reset_mid_write();
        tick();
        m_axi_areset = 1'b1;
        tick();
        m_axi_areset = 1'b0;
        n_checks++;
        if ({m_axi.arvalid, m_axi.awvalid, m_axi.wvalid, m_axi.rready, m_axi.bready, rsp_valid} !== 6'b0
            || dut.state !== IDLE || cmd_ready !== 1'b1 || rsp_rdata !== 64'd0 || rsp_resp !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_write: got ctl=%b state=%0d cmd_ready=%b rdata=%h resp=%b exp 000000/IDLE/1/0/00",
                     {m_axi.arvalid, m_axi.awvalid, m_axi.wvalid, m_axi.rready, m_axi.bready, rsp_valid},
                     dut.state, cmd_ready, rsp_rdata, rsp_resp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish exp finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_axi_areset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rdata = '0; m_axi.rresp = '0;
        m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0; m_axi.bresp = '0;

        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_same_cycle();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_write();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
